// File: rtl/soundweb_uart_tx_if.sv
// Signal bundle between the HPS/encoder side and the Soundweb UART transmitter.
// The master owns start_req/packet; the slave (transmitter) owns tx and status.
interface soundweb_uart_tx_if;
   // Handshake: a 0->1 edge on start_req is the request; it is taken only while
   // the transmitter is idle (or in its done cycle), answered by busy=1 on the
   // next cycle, and completed by a one-cycle done pulse. Requests while busy
   // are dropped, never queued. packet is sampled only on the accepted edge.
   logic         start_req;
   logic [231:0] packet;
   logic         tx;
   logic         busy;
   logic         done;
   logic [4:0]   bytes_sent;
   logic         no_etx;
   logic [2:0]   state_dbg;

   modport master (
      output start_req, packet,
      input  tx, busy, done, bytes_sent, no_etx, state_dbg
   );

   modport slave (
      input  start_req, packet,
      output tx, busy, done, bytes_sent, no_etx, state_dbg
   );
endinterface

// File: rtl/soundweb_uart_tx.sv
// Serialises a snapshotted 29-byte Soundweb packet as back-to-back 8N1/8N2 UART
// frames, stopping after the ETX byte or after byte 28 (flagging no_etx).
module soundweb_uart_tx #(
   parameter int unsigned CLKS_PER_BIT = 434,
   parameter int unsigned STOP_BITS    = 1,
   parameter int unsigned PACKET_BYTES = 29,
   parameter logic [7:0]  ETX_BYTE     = 8'h03
) (
   input  logic              fpga_clk_50,
   input  logic              hps_fpga_reset_n,
   soundweb_uart_tx_if.slave sw
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_STOP   = 3'd3,
      S_FINISH = 3'd4
   } state_t;

   localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);
   localparam logic [2:0]  STOP_LAST = 3'(STOP_BITS - 1);
   localparam logic [4:0]  LAST_IDX  = 5'(PACKET_BYTES - 1);

   state_t      state_q, state_d;
   logic        start_q, start_d;
   logic [15:0] baud_q, baud_d;
   logic [2:0]  bit_q, bit_d;
   logic [4:0]  idx_q, idx_d;
   logic        tx_q, tx_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic [4:0]  bytes_sent_q, bytes_sent_d;
   logic        no_etx_q, no_etx_d;
   logic [7:0]  buf_q [PACKET_BYTES];
   logic [7:0]  buf_d [PACKET_BYTES];

   logic        start_evt;
   logic        accept;
   logic        baud_last;
   logic [7:0]  cur_byte;

   always_comb begin
      start_d      = sw.start_req;
      state_d      = state_q;
      baud_d       = baud_q;
      bit_d        = bit_q;
      idx_d        = idx_q;
      tx_d         = tx_q;
      busy_d       = busy_q;
      done_d       = 1'b0;
      bytes_sent_d = bytes_sent_q;
      no_etx_d     = no_etx_q;
      buf_d        = buf_q;
      accept       = 1'b0;

      start_evt = sw.start_req & ~start_q;
      baud_last = (baud_q == BAUD_LAST);
      cur_byte  = buf_q[idx_q];

      case (state_q)
         S_IDLE: begin
            accept = start_evt;
         end

         // An edge arriving in the done cycle is honoured as if already idle.
         S_FINISH: begin
            accept  = start_evt;
            state_d = S_IDLE;
         end

         S_START: begin
            baud_d = baud_q + 16'd1;
            if (baud_last) begin
               baud_d  = 16'd0;
               bit_d   = 3'd0;
               tx_d    = cur_byte[0];
               state_d = S_DATA;
            end
         end

         S_DATA: begin
            baud_d = baud_q + 16'd1;
            if (baud_last) begin
               baud_d = 16'd0;
               if (bit_q == 3'd7) begin
                  bit_d   = 3'd0;
                  tx_d    = 1'b1;
                  state_d = S_STOP;
               end else begin
                  bit_d = bit_q + 3'd1;
                  tx_d  = cur_byte[bit_q + 3'd1];
               end
            end
         end

         S_STOP: begin
            baud_d = baud_q + 16'd1;
            if (baud_last) begin
               baud_d = 16'd0;
               if (bit_q == STOP_LAST) begin
                  bit_d        = 3'd0;
                  bytes_sent_d = idx_q + 5'd1;
                  if ((cur_byte == ETX_BYTE) || (idx_q == LAST_IDX)) begin
                     if (cur_byte != ETX_BYTE) begin
                        no_etx_d = 1'b1;
                     end
                     tx_d    = 1'b1;
                     busy_d  = 1'b0;
                     done_d  = 1'b1;
                     state_d = S_FINISH;
                  end else begin
                     idx_d   = idx_q + 5'd1;
                     tx_d    = 1'b0;
                     state_d = S_START;
                  end
               end else begin
                  bit_d = bit_q + 3'd1;
               end
            end
         end

         default: begin
            state_d = S_IDLE;
            tx_d    = 1'b1;
            busy_d  = 1'b0;
         end
      endcase

      // Snapshot the packet so later encoder updates cannot corrupt the frame.
      if (accept) begin
         for (int i = 0; i < int'(PACKET_BYTES); i++) begin
            buf_d[i] = sw.packet[8*(int'(PACKET_BYTES)-1-i) +: 8];
         end
         state_d      = S_START;
         busy_d       = 1'b1;
         bytes_sent_d = 5'd0;
         no_etx_d     = 1'b0;
         idx_d        = 5'd0;
         bit_d        = 3'd0;
         baud_d       = 16'd0;
         tx_d         = 1'b0;
      end
   end

   always_ff @(posedge fpga_clk_50 or negedge hps_fpga_reset_n) begin
      if (!hps_fpga_reset_n) begin
         state_q      <= S_IDLE;
         start_q      <= 1'b0;
         baud_q       <= 16'd0;
         bit_q        <= 3'd0;
         idx_q        <= 5'd0;
         tx_q         <= 1'b1;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         bytes_sent_q <= 5'd0;
         no_etx_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         start_q      <= start_d;
         baud_q       <= baud_d;
         bit_q        <= bit_d;
         idx_q        <= idx_d;
         tx_q         <= tx_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         bytes_sent_q <= bytes_sent_d;
         no_etx_q     <= no_etx_d;
      end
   end

   // Data-only storage; its contents are don't-care until the next snapshot.
   always_ff @(posedge fpga_clk_50) begin
      buf_q <= buf_d;
   end

   assign sw.tx         = tx_q;
   assign sw.busy       = busy_q;
   assign sw.done       = done_q;
   assign sw.bytes_sent = bytes_sent_q;
   assign sw.no_etx     = no_etx_q;
   assign sw.state_dbg  = state_q;

endmodule

// File: tb/tb_soundweb_uart_tx.sv
// Bench for soundweb_uart_tx: a wire-level reference model fills expectation
// queues at each accepted start; a monitor checks each busy run against them.
module tb_soundweb_uart_tx;

   localparam int C = 4;

   logic fpga_clk_50 = 1'b0;
   logic hps_fpga_reset_n;

   soundweb_uart_tx_if sw1 ();
   soundweb_uart_tx_if sw2 ();

   soundweb_uart_tx #(.CLKS_PER_BIT(C), .STOP_BITS(1)) u_dut1 (
      .fpga_clk_50      (fpga_clk_50),
      .hps_fpga_reset_n (hps_fpga_reset_n),
      .sw               (sw1)
   );

   soundweb_uart_tx #(.CLKS_PER_BIT(C), .STOP_BITS(2)) u_dut2 (
      .fpga_clk_50      (fpga_clk_50),
      .hps_fpga_reset_n (hps_fpga_reset_n),
      .sw               (sw2)
   );

   always #10 fpga_clk_50 = ~fpga_clk_50;

   int total = 0;
   int bad   = 0;

   logic       exp_wire_q [$];
   int         exp_len_q [$];
   logic [4:0] exp_q [$];
   logic       exp_noetx_q [$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic logic [7:0] pkt_byte(input logic [231:0] p, input int k);
      return p[8*(28-k) +: 8];
   endfunction

   function automatic int model_nbytes(input logic [231:0] p);
      for (int k = 0; k < 29; k++) begin
         if (pkt_byte(p, k) == 8'h03) return k + 1;
      end
      return 29;
   endfunction

   // Line level at cycle t after the tx falling edge of byte 0.
   function automatic logic model_tx(input logic [231:0] p, input int stop_bits, input int t);
      int frame;
      int k;
      int pos;
      logic [7:0] b;
      frame = (9 + stop_bits) * C;
      k     = t / frame;
      pos   = (t % frame) / C;
      b     = pkt_byte(p, k);
      if (pos == 0) return 1'b0;
      if (pos <= 8) return b[pos-1];
      return 1'b1;
   endfunction

   task automatic push_expect(input logic [231:0] p);
      int n;
      n = model_nbytes(p);
      for (int t = 0; t < n * 10 * C; t++) exp_wire_q.push_back(model_tx(p, 1, t));
      exp_len_q.push_back(n * 10 * C);
      exp_q.push_back(5'(n));
      exp_noetx_q.push_back((n == 29) && (pkt_byte(p, 28) != 8'h03));
   endtask

   function automatic logic [7:0] non_etx();
      logic [7:0] b;
      b = 8'($urandom_range(0, 255));
      if (b == 8'h03) b = 8'h04;
      return b;
   endfunction

   function automatic logic [231:0] rand_pkt();
      logic [231:0] p;
      int n;
      logic [7:0] b;
      n = $urandom_range(1, 29);
      for (int k = 0; k < 29; k++) begin
         if (k < n - 1) b = non_etx();
         else if (k == n - 1) b = ((n < 29) || ($urandom_range(0, 1) == 1)) ? 8'h03 : non_etx();
         else b = 8'($urandom_range(0, 255));
         p[8*(28-k) +: 8] = b;
      end
      return p;
   endfunction

   function automatic logic [231:0] scramble();
      logic [255:0] r;
      r = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      return r[231:0];
   endfunction

   // ---------------- monitor / scoreboard ----------------
   int   run_len;
   int   run_mism;
   logic done_prev;
   logic exp_bit;

   always @(negedge fpga_clk_50) begin
      if (!hps_fpga_reset_n) begin
         run_len   = 0;
         run_mism  = 0;
         done_prev = 1'b0;
      end else begin
         if (sw1.busy) begin
            run_len++;
            if (exp_wire_q.size() != 0) begin
               exp_bit = exp_wire_q.pop_front();
               if (sw1.tx !== exp_bit) run_mism++;
            end
         end
         if (sw1.done) begin
            check("done_not_busy", 32'(sw1.busy), 32'd0);
            check("done_single_cycle", 32'(done_prev), 32'd0);
            check("done_tx_idle", 32'(sw1.tx), 32'd1);
            if (exp_len_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_done: got done=1 expected no packet at %0t", $time);
            end else begin
               check("busy_len", 32'(run_len), 32'(exp_len_q.pop_front()));
               check("wire_mismatch_cycles", 32'(run_mism), 32'd0);
               check("bytes_sent", 32'(sw1.bytes_sent), 32'(exp_q.pop_front()));
               check("no_etx", 32'(sw1.no_etx), 32'(exp_noetx_q.pop_front()));
            end
            run_len  = 0;
            run_mism = 0;
         end
         done_prev = sw1.done;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic start_pkt(input logic [231:0] p, input bit accept, input bit hold);
      sw1.packet    = p;
      sw1.start_req = 1'b1;
      if (accept) push_expect(p);
      @(posedge fpga_clk_50);
      #1;
      if (accept) begin
         check("latency_busy", 32'(sw1.busy), 32'd1);
         check("latency_tx_low", 32'(sw1.tx), 32'd0);
      end
      if (!hold) sw1.start_req = 1'b0;
      sw1.packet = scramble();
   endtask

   task automatic wait_done(input int budget);
      int i;
      i = 0;
      while (i < budget) begin
         @(negedge fpga_clk_50);
         if (sw1.done) break;
         i++;
      end
      total++;
      if (i >= budget) begin
         bad++;
         $display("FAIL wait_done: got no done expected done within %0d cycles", budget);
      end
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   logic [231:0] pkt1;
   logic [231:0] pkt_a;
   logic [231:0] pkt_b;
   logic [231:0] pkt5;
   int           mism2;
   int           busy2;

   initial begin
      hps_fpga_reset_n = 1'b0;
      sw1.start_req    = 1'b0;
      sw1.packet       = '0;
      sw2.start_req    = 1'b0;
      sw2.packet       = '0;
      repeat (3) @(posedge fpga_clk_50);
      #1;
      check("rst_tx", 32'(sw1.tx), 32'd1);
      check("rst_busy", 32'(sw1.busy), 32'd0);
      check("rst_done", 32'(sw1.done), 32'd0);
      check("rst_bytes_sent", 32'(sw1.bytes_sent), 32'd0);
      check("rst_no_etx", 32'(sw1.no_etx), 32'd0);
      check("rst_tx2", 32'(sw2.tx), 32'd1);
      hps_fpga_reset_n = 1'b1;
      repeat (2) @(posedge fpga_clk_50);
      #1;

      // Short packet terminated by ETX at byte 3; the FF tail must never appear.
      pkt1 = {8'h02, 8'h8D, 8'h1E, 8'h03, {25{8'hFF}}};
      start_pkt(pkt1, 1'b1, 1'b0);
      wait_done(300);
      @(posedge fpga_clk_50);
      #1;
      check("t1_bytes_sent_hold", 32'(sw1.bytes_sent), 32'd4);
      check("t1_no_etx_hold", 32'(sw1.no_etx), 32'd0);

      // No ETX anywhere: full 29 frames and sticky no_etx.
      start_pkt({29{8'h55}}, 1'b1, 1'b0);
      wait_done(1300);
      repeat (3) @(posedge fpga_clk_50);
      #1;
      check("t2_no_etx_hold", 32'(sw1.no_etx), 32'd1);
      check("t2_bytes_sent_hold", 32'(sw1.bytes_sent), 32'd29);

      // Next accepted start clears status; a mid-packet restart is ignored.
      pkt_a = {8'hA5, 8'h5A, 8'h3C, 8'h03, {25{8'h03}}};
      start_pkt(pkt_a, 1'b1, 1'b0);
      check("t3_no_etx_cleared", 32'(sw1.no_etx), 32'd0);
      check("t3_bytes_sent_cleared", 32'(sw1.bytes_sent), 32'd0);
      repeat (45) @(posedge fpga_clk_50);
      #1;
      start_pkt({8'h03, {28{8'hEE}}}, 1'b0, 1'b0);
      wait_done(400);
      repeat (30) @(posedge fpga_clk_50);
      #1;
      check("t3_idle_after", 32'(sw1.busy), 32'd0);

      // Randomized packets with random gaps.
      for (int r = 0; r < 6; r++) begin
         start_pkt(rand_pkt(), 1'b1, 1'b0);
         wait_done(1300);
         repeat ($urandom_range(1, 5)) @(posedge fpga_clk_50);
         #1;
      end

      // Asynchronous reset in the middle of a data bit of byte 2.
      start_pkt({29{8'h55}}, 1'b1, 1'b0);
      repeat (94) @(posedge fpga_clk_50);
      #1;
      check("t4_bytes_before_rst", 32'(sw1.bytes_sent), 32'd2);
      @(posedge fpga_clk_50);
      #2;
      hps_fpga_reset_n = 1'b0;
      #1;
      check("t4_rst_tx", 32'(sw1.tx), 32'd1);
      check("t4_rst_busy", 32'(sw1.busy), 32'd0);
      check("t4_rst_bytes_sent", 32'(sw1.bytes_sent), 32'd0);
      exp_wire_q.delete();
      exp_len_q.delete();
      exp_q.delete();
      exp_noetx_q.delete();
      repeat (2) @(posedge fpga_clk_50);
      #3;
      hps_fpga_reset_n = 1'b1;
      @(posedge fpga_clk_50);
      #1;
      start_pkt(pkt1, 1'b1, 1'b0);
      wait_done(300);
      @(posedge fpga_clk_50);
      #1;

      // Two stop bits on the second instance: one 44-cycle frame.
      pkt5 = {8'h03, {28{8'h55}}};
      sw2.packet    = pkt5;
      sw2.start_req = 1'b1;
      @(posedge fpga_clk_50);
      #1;
      sw2.start_req = 1'b0;
      sw2.packet    = scramble();
      mism2 = 0;
      busy2 = 0;
      for (int t = 0; t < 44; t++) begin
         if (sw2.tx !== model_tx(pkt5, 2, t)) mism2++;
         if (sw2.busy) busy2++;
         @(posedge fpga_clk_50);
         #1;
      end
      check("t5_wire_mismatch_cycles", 32'(mism2), 32'd0);
      check("t5_busy_len", 32'(busy2), 32'd44);
      check("t5_done", 32'(sw2.done), 32'd1);
      check("t5_busy_low", 32'(sw2.busy), 32'd0);
      check("t5_bytes_sent", 32'(sw2.bytes_sent), 32'd1);
      @(posedge fpga_clk_50);
      #1;
      check("t5_done_one_cycle", 32'(sw2.done), 32'd0);

      // start_req held high across done: exactly one packet.
      pkt_b = {8'h11, 8'h03, {27{8'h77}}};
      start_pkt(pkt_b, 1'b1, 1'b1);
      wait_done(200);
      repeat (10) @(posedge fpga_clk_50);
      #1;
      check("t6_hold_no_restart", 32'(sw1.busy), 32'd0);
      sw1.start_req = 1'b0;
      @(posedge fpga_clk_50);
      #1;

      // Fresh edge issued in the done cycle starts the next packet 1 cycle later.
      start_pkt(pkt_b, 1'b1, 1'b0);
      wait_done(200);
      start_pkt(rand_pkt(), 1'b1, 1'b0);
      wait_done(1300);
      repeat (20) @(posedge fpga_clk_50);
      #1;
      check("queue_drained", 32'(exp_q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
